// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns the UART RX byte stream into validated
// <cmd><val0><val1><CR|LF> frames for the cold-storage controller.
// Ports: clk, rst (sync, active-high), rx_data/rx_valid (byte strobe),
//   chr_cmd/chr_val0/chr_val1 (committed frame), rx_msg_done (held
//   DONE_CYCLES per commit), frame_err (1-cycle reject pulse).
// Optional: `define UART_CMD_PARSER_STATS_EN adds stats_clr, err_count,
//   ovr_count (saturating reject / pending-overwrite counters).
module uart_cmd_parser #(
    parameter int CLK_HZ         = 1_000_000,
    parameter int TIMEOUT_CYCLES = 100_000,
    parameter int DONE_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
`ifdef UART_CMD_PARSER_STATS_EN
    input  logic       stats_clr,
    output logic [7:0] err_count,
    output logic [7:0] ovr_count,
`endif
    output logic [7:0] chr_cmd,
    output logic [7:0] chr_val0,
    output logic [7:0] chr_val1,
    output logic       rx_msg_done,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(DONE_CYCLES + 1);

    if (DONE_CYCLES < 2 || CLK_HZ < 1) begin : g_bad_cfg
        $error("uart_cmd_parser: bad parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_VAL0,
        S_VAL1,
        S_TERM
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_tcnt;
    logic [HW-1:0]   r_hold;
    logic [7:0]      r_cmd;
    logic [7:0]      r_val0;
    logic [7:0]      r_val1;
    logic [7:0]      r_pend_cmd;
    logic [7:0]      r_pend_val0;
    logic [7:0]      r_pend_val1;
    logic            r_pend;
    logic            r_done_q;

    logic w_ws;
    logic w_cmd_ok;
    logic w_is_l;
    logic w_bit;
    logic w_dig;
    logic w_eol;
    logic w_timeout;
    logic w_commit;
    logic w_err;
    logic w_complete;
    logic w_ld_cmd;
    logic w_ld_v0;
    logic w_ld_v1;

    assign w_ws     = rx_data inside {8'h0D, 8'h0A, 8'h20};
    assign w_cmd_ok = rx_data inside {[8'h41:8'h44], 8'h4C,
                                      [8'h61:8'h64], 8'h6C};
    assign w_is_l   = (r_cmd == 8'h4C);
    assign w_bit    = rx_data inside {8'h30, 8'h31};
    assign w_dig    = rx_data inside {[8'h30:8'h39]};
    assign w_eol    = rx_data inside {8'h0D, 8'h0A};

    // A byte arriving this cycle always beats the timeout.
    assign w_timeout = (r_state != S_IDLE) && !rx_valid &&
                       (r_tcnt == TW'(TIMEOUT_CYCLES));

    // Two low cycles seen (now and previous) guarantee a fresh rising edge.
    assign w_commit = r_pend && !rx_msg_done && !r_done_q;

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_complete = 1'b0;
        w_ld_cmd   = 1'b0;
        w_ld_v0    = 1'b0;
        w_ld_v1    = 1'b0;
        if (w_timeout) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
        end else if (rx_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cmd_ok) begin
                        w_ld_cmd = 1'b1;
                        w_next   = S_VAL0;
                    end else if (!w_ws) begin
                        w_err = 1'b1;
                    end
                end
                S_VAL0: begin
                    if (w_is_l ? w_bit : (w_dig || rx_data == 8'h2D)) begin
                        w_ld_v0 = 1'b1;
                        w_next  = S_VAL1;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end
                end
                S_VAL1: begin
                    if (w_is_l ? w_bit : w_dig) begin
                        w_ld_v1 = 1'b1;
                        w_next  = S_TERM;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end
                end
                S_TERM: begin
                    w_complete = w_eol;
                    w_err      = !w_eol;
                    w_next     = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_hold      <= '0;
            r_cmd       <= 8'h20;
            r_val0      <= 8'h20;
            r_val1      <= 8'h20;
            r_pend_cmd  <= 8'h20;
            r_pend_val0 <= 8'h20;
            r_pend_val1 <= 8'h20;
            r_pend      <= 1'b0;
            r_done_q    <= 1'b0;
            chr_cmd     <= 8'h20;
            chr_val0    <= 8'h20;
            chr_val1    <= 8'h20;
            rx_msg_done <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            frame_err <= w_err;
            r_done_q  <= rx_msg_done;

            if (r_state == S_IDLE || rx_valid || w_timeout)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + 1'b1;

            // Only letters reach here, so clearing bit 5 uppercases.
            if (w_ld_cmd) r_cmd  <= rx_data & 8'hDF;
            if (w_ld_v0)  r_val0 <= rx_data;
            if (w_ld_v1)  r_val1 <= rx_data;

            if (w_complete) begin
                r_pend_cmd  <= r_cmd;
                r_pend_val0 <= r_val0;
                r_pend_val1 <= r_val1;
            end

            // A frame completing on the commit edge stays pending.
            if (w_complete)
                r_pend <= 1'b1;
            else if (w_commit)
                r_pend <= 1'b0;

            if (w_commit) begin
                chr_cmd     <= r_pend_cmd;
                chr_val0    <= r_pend_val0;
                chr_val1    <= r_pend_val1;
                rx_msg_done <= 1'b1;
                r_hold      <= HW'(DONE_CYCLES - 1);
            end else if (rx_msg_done) begin
                if (r_hold == '0)
                    rx_msg_done <= 1'b0;
                else
                    r_hold <= r_hold - 1'b1;
            end
        end
    end

`ifdef UART_CMD_PARSER_STATS_EN
    logic w_ovr;

    // Pending consumed on this edge is not an overwrite.
    assign w_ovr = w_complete && r_pend && !w_commit;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            err_count <= '0;
            ovr_count <= '0;
        end else begin
            if (w_err && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
            if (w_ovr && ovr_count != 8'hFF)
                ovr_count <= ovr_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed self-checking bench for uart_cmd_parser.
// Short TIMEOUT_CYCLES keeps the stall scenario brief.
module tb_uart_cmd_parser;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] chr_cmd;
    logic [7:0] chr_val0;
    logic [7:0] chr_val1;
    logic       rx_msg_done;
    logic       frame_err;
`ifdef UART_CMD_PARSER_STATS_EN
    logic       stats_clr;
    logic [7:0] err_count;
    logic [7:0] ovr_count;
`endif

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int rises = 0;
    logic prev_done = 1'b0;
    int e0;
    int r0;
    int n;

    uart_cmd_parser #(
        .CLK_HZ(1_000_000),
        .TIMEOUT_CYCLES(TMO),
        .DONE_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
`ifdef UART_CMD_PARSER_STATS_EN
        .stats_clr(stats_clr),
        .err_count(err_count),
        .ovr_count(ovr_count),
`endif
        .chr_cmd(chr_cmd),
        .chr_val0(chr_val0),
        .chr_val1(chr_val1),
        .rx_msg_done(rx_msg_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_err) err_seen++;
        if (rx_msg_done && !prev_done) rises++;
        prev_done = rx_msg_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!rx_msg_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, rx_msg_done}, 32'd1);
    endtask

    task automatic wait_low(input string tag);
        int k = 0;
        while (rx_msg_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, rx_msg_done}, 32'd0);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] c,
                             input logic [7:0] v0, input logic [7:0] v1);
        chk({tag, "_cmd"}, {24'd0, chr_cmd}, {24'd0, c});
        chk({tag, "_v0"}, {24'd0, chr_val0}, {24'd0, v0});
        chk({tag, "_v1"}, {24'd0, chr_val1}, {24'd0, v1});
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
`ifdef UART_CMD_PARSER_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_frame("rst", 8'h20, 8'h20, 8'h20);
        chk("rst_done", {31'd0, rx_msg_done}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
`ifdef UART_CMD_PARSER_STATS_EN
        chk("rst_errc", {24'd0, err_count}, 32'd0);
        chk("rst_ovrc", {24'd0, ovr_count}, 32'd0);
`endif

        // "A25\n", slow byte spacing, exact latency and hold length
        e0 = err_seen;
        r0 = rises;
        send("A", 100);
        send("2", 100);
        send("5", 100);
        send(8'h0A, 0);
        chk("t1_lat1", {31'd0, rx_msg_done}, 32'd0);
        @(negedge clk);
        chk("t1_lat2", {31'd0, rx_msg_done}, 32'd1);
        n = 0;
        while (rx_msg_done && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("t1_hold", n, 16);
        chk_frame("t1", 8'h41, 8'h32, 8'h35);
        chk("t1_noerr", err_seen - e0, 0);
        chk("t1_rises", rises - r0, 1);

        // lowercase cmd, '-' value, CR terminator; then an invalid L frame
        send_str("b-5\r", 3);
        wait_done("t2_done");
        chk_frame("t2", 8'h42, 8'h2D, 8'h35);
        wait_low("t2_low");
        e0 = err_seen;
        r0 = rises;
        send_str("L12\n", 3);
        repeat (30) @(negedge clk);
        chk("t2_err", err_seen - e0, 1);
        chk("t2_norise", rises - r0, 0);
        chk_frame("t2_keep", 8'h42, 8'h2D, 8'h35);

        // stall inside a frame
        e0 = err_seen;
        send_str("C3", 3);
        repeat (150) @(negedge clk);
        chk("t3_early", err_seen - e0, 0);
        repeat (80) @(negedge clk);
        chk("t3_tmo", err_seen - e0, 1);
        e0 = err_seen;
        send_str("C30\n", 3);
        wait_done("t3_done");
        chk_frame("t3", 8'h43, 8'h33, 8'h30);
        chk("t3_noerr", err_seen - e0, 0);
        wait_low("t3_low");
        repeat (3) @(negedge clk);

        // back-to-back frames: second waits for the low gap
        send_str("D10\n", 1);
        send_str("L01\n", 1);
        chk("t4_dhigh", {31'd0, rx_msg_done}, 32'd1);
        chk_frame("t4_d", 8'h44, 8'h31, 8'h30);
        wait_low("t4_low1");
        chk("t4_keep", {24'd0, chr_cmd}, 32'h44);
        @(negedge clk);
        chk("t4_low2", {31'd0, rx_msg_done}, 32'd0);
        @(negedge clk);
        chk("t4_rise", {31'd0, rx_msg_done}, 32'd1);
        chk_frame("t4_l", 8'h4C, 8'h30, 8'h31);
        wait_low("t4_end");

        // reset mid-frame
        send_str("A1", 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_frame("t5_rst", 8'h20, 8'h20, 8'h20);
        chk("t5_rdone", {31'd0, rx_msg_done}, 32'd0);
        chk("t5_rferr", {31'd0, frame_err}, 32'd0);
        e0 = err_seen;
        r0 = rises;
        send(8'h0A, 3);
        repeat (10) @(negedge clk);
        chk("t5_lf_err", err_seen - e0, 0);
        chk("t5_lf_rise", rises - r0, 0);
        send_str("A18\n", 3);
        wait_done("t5_done");
        chk_frame("t5", 8'h41, 8'h31, 8'h38);
        wait_low("t5_low");
        repeat (3) @(negedge clk);

        // latest pending frame wins
        e0 = err_seen;
        r0 = rises;
        send_str("A11\nA22\nA33\n", 0);
        chk_frame("t6_first", 8'h41, 8'h31, 8'h31);
        wait_low("t6_low");
        wait_done("t6_done");
        chk_frame("t6_last", 8'h41, 8'h33, 8'h33);
        chk("t6_rises", rises - r0, 2);
        chk("t6_noerr", err_seen - e0, 0);
        wait_low("t6_end");

`ifdef UART_CMD_PARSER_STATS_EN
        chk("s_ovr", {24'd0, ovr_count}, 32'd1);
        send_str("X", 3);
        send_str("A1Z", 3);
        send_str("A12Q", 3);
        repeat (3) @(negedge clk);
        chk("s_err", {24'd0, err_count}, 32'd3);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("s_clr_err", {24'd0, err_count}, 32'd0);
        chk("s_clr_ovr", {24'd0, ovr_count}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
